// File: rtl/usb_pkg.sv
// Shared USB link-layer definitions: PID codes, PID type field, length limit, RX router states.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package usb_pkg;

  // Token PIDs
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SOF   = 8'hA5;
  localparam logic [7:0] PID_SETUP = 8'h2D;

  // Data PIDs
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_DATA2 = 8'h87;
  localparam logic [7:0] PID_MDATA = 8'h0F;

  // Handshake PIDs
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_NYET  = 8'h96;

  // PID[1:0] of every data-class PID
  localparam logic [1:0] PID_TYPE_DATA = 2'b11;

  // PID + 1024 payload bytes + CRC16
  localparam int MAX_PKT_LEN_DEF = 1027;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ROUTE_TO = 2'd1,
    ST_ROUTE_LT = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_t;

  // The upper nibble of a PID byte is the ones' complement of the lower nibble
  function automatic logic pid_is_valid(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

endpackage

// File: rtl/rx_stream_reg.sv
// Single register stage carrying one sop/eop/data byte beat toward a consumer.
// Latency: 1 cycle from load to out_valid.
// Backpressure: can_load = ~out_valid | out_ready, so a full stage drains and reloads in the same cycle.
module rx_stream_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       in_sop,
  input  logic       in_eop,
  input  logic [7:0] in_data,
  output logic       can_load,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  assign can_load = ~out_valid | out_ready;

  // Valid flag: set on load, cleared when the held beat drains without a replacement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Payload is captured only when a beat is loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      out_data <= 8'h00;
    end else if (load) begin
      out_sop  <= in_sop;
      out_eop  <= in_eop;
      out_data <= in_data;
    end
  end

endmodule

// File: rtl/control_r.sv
// RX packet router: decodes the PID at SOP and steers the packet to the token/handshake or data stream.
// Latency: 1 cycle PHY beat to output beat; status pulses are combinational with the accepted beat.
// Backpressure: PHY ready follows the selected output stage; discarded beats (bad PID, DROP) are always accepted.
module control_r
  import usb_pkg::*;
#(
  parameter int MAX_PKT_LEN = MAX_PKT_LEN_DEF,
  parameter int LEN_W       = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pl_sop,
  input  logic       rx_pl_eop,
  input  logic       rx_pl_valid,
  output logic       rx_pl_ready,
  input  logic [7:0] rx_pl_data,
  output logic       rx_to_sop,
  output logic       rx_to_eop,
  output logic       rx_to_valid,
  input  logic       rx_to_ready,
  output logic [7:0] rx_to_data,
  output logic       rx_lt_sop,
  output logic       rx_lt_eop,
  output logic       rx_lt_valid,
  input  logic       rx_lt_ready,
  output logic [7:0] rx_lt_data,
  output logic       rx_data_on,
  output logic       rx_lp_eop_en,
  output logic       rx_pid_err,
  output logic       rx_len_err
);

  rx_state_t        state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             data_on_nxt;
  logic             to_can, lt_can;
  logic             pid_ok, pid_data, decode;
  logic             sel_to, sel_lt;
  logic             acc, load_to, load_lt, trunc, fwd_eop;

  assign pid_ok   = pid_is_valid(rx_pl_data);
  assign pid_data = (rx_pl_data[1:0] == PID_TYPE_DATA);
  // A sop beat mid-packet is treated exactly like a packet start in IDLE
  assign decode   = (state == ST_IDLE) ||
                    (((state == ST_ROUTE_TO) || (state == ST_ROUTE_LT)) && rx_pl_sop);

  // Path selection for the current PHY beat; neither path selected means discard
  always_comb begin
    sel_to = 1'b0;
    sel_lt = 1'b0;
    if (decode) begin
      if (rx_pl_sop && pid_ok) begin
        sel_lt = pid_data;
        sel_to = ~pid_data;
      end
    end else if (state == ST_ROUTE_TO) begin
      sel_to = 1'b1;
    end else if (state == ST_ROUTE_LT) begin
      sel_lt = 1'b1;
    end
  end

  // Held low during reset so every output reads 0 while rst_n is asserted
  assign rx_pl_ready  = rst_n & (sel_to ? to_can : (sel_lt ? lt_can : 1'b1));
  assign acc          = rx_pl_valid & rx_pl_ready;
  assign load_to      = acc & sel_to;
  assign load_lt      = acc & sel_lt;
  assign trunc        = (load_to | load_lt) & ~decode & ~rx_pl_eop &
                        (cnt == LEN_W'(MAX_PKT_LEN - 1));
  assign fwd_eop      = rx_pl_eop | trunc;
  assign rx_lp_eop_en = acc & rx_pl_eop;
  assign rx_pid_err   = acc & decode & rx_pl_sop & ~pid_ok;
  assign rx_len_err   = trunc;

  // Next state, byte count and data-path indicator, updated only on accepted beats
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    data_on_nxt = rx_data_on;
    if (acc) begin
      if (decode) begin
        if (rx_pl_sop) begin
          cnt_nxt = LEN_W'(1);
          if (rx_pl_eop)     state_nxt = ST_IDLE;
          else if (!pid_ok)  state_nxt = ST_DROP;
          else if (pid_data) state_nxt = ST_ROUTE_LT;
          else               state_nxt = ST_ROUTE_TO;
        end
      end else if (state == ST_DROP) begin
        if (rx_pl_eop) state_nxt = ST_IDLE;
      end else begin
        cnt_nxt = cnt + LEN_W'(1);
        if (rx_pl_eop)  state_nxt = ST_IDLE;
        else if (trunc) state_nxt = ST_DROP;
      end
      // A truncated or aborted data packet keeps the indicator until its tail is dropped
      case (state_nxt)
        ST_ROUTE_LT: data_on_nxt = 1'b1;
        ST_DROP:     data_on_nxt = rx_data_on;
        default:     data_on_nxt = 1'b0;
      endcase
    end
  end

  // FSM state, byte counter and data-path indicator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rx_data_on <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rx_data_on <= data_on_nxt;
    end
  end

  rx_stream_reg u_to_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_to),
    .in_sop    (rx_pl_sop),
    .in_eop    (fwd_eop),
    .in_data   (rx_pl_data),
    .can_load  (to_can),
    .out_sop   (rx_to_sop),
    .out_eop   (rx_to_eop),
    .out_valid (rx_to_valid),
    .out_ready (rx_to_ready),
    .out_data  (rx_to_data)
  );

  rx_stream_reg u_lt_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_lt),
    .in_sop    (rx_pl_sop),
    .in_eop    (fwd_eop),
    .in_data   (rx_pl_data),
    .can_load  (lt_can),
    .out_sop   (rx_lt_sop),
    .out_eop   (rx_lt_eop),
    .out_valid (rx_lt_valid),
    .out_ready (rx_lt_ready),
    .out_data  (rx_lt_data)
  );

endmodule
